// File: rtl/spi_slv_if.sv
// Bus bundle between an SPI master model and the spi_slv responder.
// Carries the serial lines plus the host-side tx/rx word handshake.
interface spi_slv_if #(
   parameter int FRAME_BITS = 16
);
   logic                  SS_n;
   logic                  SCLK;
   logic                  MOSI;
   logic                  MISO;
   logic [FRAME_BITS-1:0] tx_data;
   logic                  wrt_tx;
   logic                  clr_rdy;
   logic [FRAME_BITS-1:0] rx_data;
   logic                  rdy;
   logic                  frm_err;

   modport master (
      output SS_n, SCLK, MOSI, tx_data, wrt_tx, clr_rdy,
      input  MISO, rx_data, rdy, frm_err
   );

   modport slave (
      input  SS_n, SCLK, MOSI, tx_data, wrt_tx, clr_rdy,
      output MISO, rx_data, rdy, frm_err
   );
endinterface

// File: rtl/spi_slv.sv
// SPI responder, CPOL=1/CPHA=1, FRAME_BITS-bit frames, oversampled by clk.
// Optional frame-error flag enabled by defining SPI_SLV_FRM_ERR_EN.
module spi_slv #(
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   spi_slv_if.slave  bus
);
   localparam int CW = $clog2(FRAME_BITS) + 1;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q, settle_q;
   logic                   ss_dly_q, sclk_dly_q, armed_q;
   logic                   ss_s, sclk_s, mosi_s;
   logic                   ss_fall, ss_rise, sclk_rise;

   state_t                 state_q, state_d;
   logic [FRAME_BITS-1:0]  tx_buf_q, tx_buf_d;
   logic [FRAME_BITS-1:0]  shft_q, shft_d;
   logic [FRAME_BITS-1:0]  rx_q, rx_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   rdy_q, rdy_d;
   logic                   miso_q, miso_d;
`ifdef SPI_SLV_FRM_ERR_EN
   logic                   frm_err_q, frm_err_d;
`endif

   // Input synchronisers plus one extra flop on SS_n/SCLK for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_sync_q <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         ss_dly_q    <= 1'b1;
         sclk_dly_q  <= 1'b1;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
         ss_dly_q    <= ss_s;
         sclk_dly_q  <= sclk_s;
      end
   end

   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // A frame already running at reset release would look like a fresh SS_n
   // fall once the synchronisers flush; only arm after SS_n is seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q <= {SYNC_STAGES{1'b0}};
         armed_q  <= 1'b0;
      end else begin
         settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
         armed_q  <= armed_q | (settle_q[SYNC_STAGES-1] & ss_s);
      end
   end

   assign ss_fall   = armed_q & ~ss_s & ss_dly_q;
   assign ss_rise   = ss_s & ~ss_dly_q;
   assign sclk_rise = sclk_s & ~sclk_dly_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tx_buf_q  <= {FRAME_BITS{1'b0}};
         shft_q    <= {FRAME_BITS{1'b0}};
         rx_q      <= {FRAME_BITS{1'b0}};
         cnt_q     <= {CW{1'b0}};
         rdy_q     <= 1'b0;
         miso_q    <= 1'b0;
`ifdef SPI_SLV_FRM_ERR_EN
         frm_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tx_buf_q  <= tx_buf_d;
         shft_q    <= shft_d;
         rx_q      <= rx_d;
         cnt_q     <= cnt_d;
         rdy_q     <= rdy_d;
         miso_q    <= miso_d;
`ifdef SPI_SLV_FRM_ERR_EN
         frm_err_q <= frm_err_d;
`endif
      end
   end

   // Next-state and datapath; an rdy set later in this block overrides clr_rdy.
   always_comb begin
      state_d   = state_q;
      shft_d    = shft_q;
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      tx_buf_d  = bus.wrt_tx ? bus.tx_data : tx_buf_q;
      rdy_d     = bus.clr_rdy ? 1'b0 : rdy_q;
`ifdef SPI_SLV_FRM_ERR_EN
      frm_err_d = frm_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               shft_d  = tx_buf_q;
               cnt_d   = {CW{1'b0}};
               rdy_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            // ss_rise is checked first so a coincident SCLK rise is dropped.
            if (ss_rise) begin
               state_d = IDLE;
               if (cnt_q == CNT_FULL) begin
                  rx_d      = shft_q;
                  rdy_d     = 1'b1;
`ifdef SPI_SLV_FRM_ERR_EN
                  frm_err_d = 1'b0;
`endif
               end else begin
`ifdef SPI_SLV_FRM_ERR_EN
                  frm_err_d = 1'b1;
`else
                  rx_d      = rx_q;
`endif
               end
            end else if (sclk_rise) begin
               shft_d = {shft_q[FRAME_BITS-2:0], mosi_s};
               cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      miso_d = (state_d == ACTIVE) ? shft_d[FRAME_BITS-1] : 1'b0;
   end

   assign bus.MISO    = miso_q;
   assign bus.rx_data = rx_q;
   assign bus.rdy     = rdy_q;
`ifdef SPI_SLV_FRM_ERR_EN
   assign bus.frm_err = frm_err_q;
`else
   assign bus.frm_err = 1'b0;
`endif
endmodule

// File: doc/spi_slv.md
Name: spi_slv

Overview:
- SPI responder (slave) for 16-bit frames, the counterpart to the team's SPI master.
- Timing is CPOL=1/CPHA=1: SCLK idles high. The master changes MOSI on SCLK fall and samples MISO just before SCLK rise. SCLK is nominally clk/64.
- Used in sensor/A2D bus models and in any on-chip block that must answer the master. Receives a 16-bit command/data word and simultaneously returns a preloaded 16-bit response word.

Parameters:
- FRAME_BITS, 16, bits per frame. The bit counter width is $clog2(FRAME_BITS)+1.
- SYNC_STAGES, 2, metastability flops on SS_n, SCLK and MOSI (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- SS_n  input  1  slave select from master, active-low, asynchronous to clk
- SCLK  input  1  serial clock from master, asynchronous to clk
- MOSI  input  1  serial data from master
- MISO  output  1  serial data to master
- tx_data  input  FRAME_BITS  response word for the next frame
- wrt_tx  input  1  1-clk strobe that captures tx_data into the tx buffer
- clr_rdy  input  1  clears rdy
- rx_data  output  FRAME_BITS  last complete received word
- rdy  output  1  a new rx_data word is valid
- frm_err  output  1  last frame was malformed (optional feature only)

Behaviour:
- Reset, asynchronous:
  - sync flops: SS_n and SCLK to 1, MOSI to 0
  - tx_buf, shft_reg, rx_data, bit_cnt all 0
  - rdy=0, frm_err=0, MISO=0, state=IDLE
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through SYNC_STAGES flops.
  - SCLK and SS_n get one extra flop for edge detection.
  - sclk_rise = synced high & delayed low. ss_fall and ss_rise are formed the same way.
  - MOSI is sampled from the synced stage, so it has the same age as the synced SCLK.
- tx buffer: wrt_tx loads tx_buf <= tx_data in any state. A write during a frame affects only the next frame.
- State machine, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on ss_fall. That same clk: shft_reg <= tx_buf, bit_cnt <= 0, rdy <= 0.
  - ACTIVE, on each sclk_rise: shft_reg <= {shft_reg[FRAME_BITS-2:0], MOSI_sync}, and bit_cnt increments, saturating at 2^width-1.
  - ACTIVE -> IDLE on ss_rise.
    - If bit_cnt==FRAME_BITS: rx_data <= shft_reg and rdy <= 1.
    - Otherwise rx_data and rdy are unchanged (aborted frame).
  - SCLK edges in IDLE are ignored.
- MISO:
  - Equals shft_reg[FRAME_BITS-1] while in ACTIVE, 0 in IDLE.
  - The MSB of tx_buf is valid at most SYNC_STAGES+2 clks after SS_n falls.
  - Each subsequent bit is valid at most SYNC_STAGES+2 clks after a SCLK rise, well within the 32-clk half period.
- Latency: rdy and rx_data update SYNC_STAGES+2 clks after the physical SS_n rise.
- Priority and boundaries:
  - Set of rdy beats clr_rdy in the same clk.
  - rdy is also cleared at the next ss_fall.
  - SS_n pulses with zero SCLK edges: frame aborted, no rdy.
  - More than FRAME_BITS rises: frame aborted. bit_cnt saturates and never wraps back to 16.
  - A SCLK rise coincident with ss_rise in the synced domain is ignored.
  - Async reset mid-frame returns to IDLE with no rdy. A frame already in progress when reset releases is ignored until the next ss_fall.

Optional Feature:
- Macro SPI_SLV_FRM_ERR_EN.
- Defined:
  - frm_err <= 1 on ss_rise when bit_cnt != FRAME_BITS.
  - frm_err <= 0 on ss_rise of a good frame.
  - frm_err holds otherwise and is not affected by clr_rdy.
- Undefined: frm_err is tied to 0 and no extra logic is inferred.

Test Plan:
- Reset, then wrt_tx with tx_data=16'hA5C3. Master frame sends 16'h3C96 at clk/64 in mode 3 -> master reads 16'hA5C3, rx_data=16'h3C96, rdy=1 within SYNC_STAGES+2 clks of SS_n rise.
- Back-to-back frames 16'h0001 then 16'hFFFE, with wrt_tx 16'h1234 issued mid-first-frame -> frame 1 returns the old tx_buf, frame 2 returns 16'h1234. rdy drops at the second ss_fall and reasserts with rx_data=16'hFFFE.
- clr_rdy asserted on the exact clk rdy is set -> rdy=1. clr_rdy one clk later -> rdy=0.
- SS_n raised after 9 SCLK rises with rx_data=16'h3C96 held -> rdy stays 0, rx_data stays 16'h3C96, frm_err=1 (macro defined) or 0 (undefined). A following good frame clears frm_err.
- 17 SCLK rises in one frame -> aborted as above. Toggling SCLK with SS_n high -> no state change, MISO=0.
- rst_n pulsed low after 8 bits of a frame -> all outputs reset immediately. The rest of that frame produces no rdy, and the next full frame of 16'hBEEF is received correctly.
